// File: rtl/wb_master_bfm_engine.sv
// wb_master_bfm_engine
// Single-outstanding Wishbone classic master engine. Commands arrive on a
// valid/ready request channel, are issued as one registered Wishbone cycle,
// and the result is returned on a valid/ready response channel.
// Optional feature macro: WB_MASTER_BFM_ENGINE_TIMEOUT_EN
//   defined   -> a bus-wait counter aborts a cycle after TIMEOUT_CYCLES clocks
//                and reports it as an error with rsp_timeout set.
//   undefined -> no counter; a bus cycle waits for ACK/ERR indefinitely and
//                rsp_timeout is tied low.
module wb_master_bfm_engine #(
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int WB_DATA_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                       clk,
    input  logic                       rstn,

    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [WB_ADDR_WIDTH-1:0]   req_adr,
    input  logic                       req_we,
    input  logic [WB_DATA_WIDTH/8-1:0] req_sel,
    input  logic [WB_DATA_WIDTH-1:0]   req_dat,

    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [WB_DATA_WIDTH-1:0]   rsp_dat,
    output logic                       rsp_err,
    output logic                       rsp_timeout,

    output logic                       CYC,
    output logic                       STB,
    output logic                       WE,
    output logic [WB_ADDR_WIDTH-1:0]   ADR,
    output logic [WB_DATA_WIDTH/8-1:0] SEL,
    output logic [WB_DATA_WIDTH-1:0]   DAT_W,
    input  logic [WB_DATA_WIDTH-1:0]   DAT_R,
    input  logic                       ACK,
    input  logic                       ERR
);

    localparam int SEL_WIDTH = WB_DATA_WIDTH / 8;

    // Catch illegal parameterisations at elaboration time.
    if ((WB_DATA_WIDTH % 8) != 0 || WB_DATA_WIDTH < 8) begin : g_bad_data_width
        $error("wb_master_bfm_engine: WB_DATA_WIDTH must be a non-zero multiple of 8");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("wb_master_bfm_engine: TIMEOUT_CYCLES must be in 1..65535");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RSP  = 2'd2
    } state_e;

    state_e                     state_q, state_d;

    logic                       cyc_q, cyc_d;
    logic                       stb_q, stb_d;
    logic                       we_q, we_d;
    logic [WB_ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [SEL_WIDTH-1:0]       sel_q, sel_d;
    logic [WB_DATA_WIDTH-1:0]   dat_w_q, dat_w_d;

    logic                       rsp_valid_q, rsp_valid_d;
    logic [WB_DATA_WIDTH-1:0]   rsp_dat_q, rsp_dat_d;
    logic                       rsp_err_q, rsp_err_d;

`ifdef WB_MASTER_BFM_ENGINE_TIMEOUT_EN
    // The counter holds the number of completed wait cycles in the current
    // bus cycle, so the abort fires on the edge that ends cycle TIMEOUT_CYCLES.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic                       rsp_timeout_q, rsp_timeout_d;
    logic [15:0]                tmo_cnt_q, tmo_cnt_d;
`endif

    // State and datapath registers, all cleared by synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= IDLE;
            cyc_q         <= 1'b0;
            stb_q         <= 1'b0;
            we_q          <= 1'b0;
            adr_q         <= '0;
            sel_q         <= '0;
            dat_w_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_dat_q     <= '0;
            rsp_err_q     <= 1'b0;
`ifdef WB_MASTER_BFM_ENGINE_TIMEOUT_EN
            rsp_timeout_q <= 1'b0;
            tmo_cnt_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cyc_q         <= cyc_d;
            stb_q         <= stb_d;
            we_q          <= we_d;
            adr_q         <= adr_d;
            sel_q         <= sel_d;
            dat_w_q       <= dat_w_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_dat_q     <= rsp_dat_d;
            rsp_err_q     <= rsp_err_d;
`ifdef WB_MASTER_BFM_ENGINE_TIMEOUT_EN
            rsp_timeout_q <= rsp_timeout_d;
            tmo_cnt_q     <= tmo_cnt_d;
`endif
        end
    end

    // Next-state and next-datapath logic: accept, issue, terminate, respond.
    always_comb begin
        state_d       = state_q;
        cyc_d         = cyc_q;
        stb_d         = stb_q;
        we_d          = we_q;
        adr_d         = adr_q;
        sel_d         = sel_q;
        dat_w_d       = dat_w_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_dat_d     = rsp_dat_q;
        rsp_err_d     = rsp_err_q;
`ifdef WB_MASTER_BFM_ENGINE_TIMEOUT_EN
        rsp_timeout_d = rsp_timeout_q;
        tmo_cnt_d     = tmo_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d       = BUS;
                    cyc_d         = 1'b1;
                    stb_d         = 1'b1;
                    we_d          = req_we;
                    adr_d         = req_adr;
                    sel_d         = req_sel;
                    dat_w_d       = req_dat;
                    rsp_valid_d   = 1'b0;
                    rsp_dat_d     = '0;
                    rsp_err_d     = 1'b0;
`ifdef WB_MASTER_BFM_ENGINE_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
                    tmo_cnt_d     = '0;
`endif
                end
            end

            BUS: begin
                if (ERR) begin
                    // ERR wins even when ACK is asserted alongside it.
                    state_d     = RSP;
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_dat_d   = '0;
                end else if (ACK) begin
                    state_d     = RSP;
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_dat_d   = we_q ? '0 : DAT_R;
                end
`ifdef WB_MASTER_BFM_ENGINE_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    state_d       = RSP;
                    cyc_d         = 1'b0;
                    stb_d         = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_dat_d     = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
`endif
            end

            RSP: begin
                if (rsp_ready) begin
                    state_d       = IDLE;
                    rsp_valid_d   = 1'b0;
                    rsp_dat_d     = '0;
                    rsp_err_d     = 1'b0;
`ifdef WB_MASTER_BFM_ENGINE_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
`endif
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode: only req_ready is state-derived, the bus and response
    // ports come straight from registers.
    always_comb begin
        req_ready   = rstn && (state_q == IDLE);
        CYC         = cyc_q;
        STB         = stb_q;
        WE          = we_q;
        ADR         = adr_q;
        SEL         = sel_q;
        DAT_W       = dat_w_q;
        rsp_valid   = rsp_valid_q;
        rsp_dat     = rsp_dat_q;
        rsp_err     = rsp_err_q;
`ifdef WB_MASTER_BFM_ENGINE_TIMEOUT_EN
        rsp_timeout = rsp_timeout_q;
`else
        rsp_timeout = 1'b0;
`endif
    end

endmodule

// File: tb/tb_wb_master_bfm_engine.sv
// tb_wb_master_bfm_engine
// Directed bench for wb_master_bfm_engine: reset, write, read, response
// backpressure, ACK+ERR collision, stray bus responses, bus wait behaviour
// (timeout when WB_MASTER_BFM_ENGINE_TIMEOUT_EN is defined, indefinite wait
// otherwise) and reset in the middle of a bus cycle.
module tb_wb_master_bfm_engine;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   logic          clk;
   logic          rstn;
   logic          reqValid;
   logic          reqReady;
   logic [AW-1:0] reqAdr;
   logic          reqWe;
   logic [SW-1:0] reqSel;
   logic [DW-1:0] reqDat;
   logic          rspValid;
   logic          rspReady;
   logic [DW-1:0] rspDat;
   logic          rspErr;
   logic          rspTimeout;
   logic          cyc;
   logic          stb;
   logic          we;
   logic [AW-1:0] adr;
   logic [SW-1:0] sel;
   logic [DW-1:0] datW;
   logic [DW-1:0] datR;
   logic          ack;
   logic          err;

   int testCount;
   int failCount;

   wb_master_bfm_engine #(
      .WB_ADDR_WIDTH  (AW),
      .WB_DATA_WIDTH  (DW),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .req_valid   (reqValid),
      .req_ready   (reqReady),
      .req_adr     (reqAdr),
      .req_we      (reqWe),
      .req_sel     (reqSel),
      .req_dat     (reqDat),
      .rsp_valid   (rspValid),
      .rsp_ready   (rspReady),
      .rsp_dat     (rspDat),
      .rsp_err     (rspErr),
      .rsp_timeout (rspTimeout),
      .CYC         (cyc),
      .STB         (stb),
      .WE          (we),
      .ADR         (adr),
      .SEL         (sel),
      .DAT_W       (datW),
      .DAT_R       (datR),
      .ACK         (ack),
      .ERR         (err)
   );

   // Free-running 100 MHz-style clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expected value and count it.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drive the request channel.
   task automatic applyStimulus(input logic valid, input logic [AW-1:0] a, input logic w,
                                input logic [SW-1:0] s, input logic [DW-1:0] d);
      reqValid = valid;
      reqAdr   = a;
      reqWe    = w;
      reqSel   = s;
      reqDat   = d;
   endtask

   // Advance one clock and settle just after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Complete a response handshake and confirm the engine is idle again.
   task automatic drainResponse(input string tag);
      rspReady = 1'b1;
      tick();
      rspReady = 1'b0;
      checkOutput({tag, "_rsp_cleared"}, 64'(rspValid), 64'd0);
      checkOutput({tag, "_ready_again"}, 64'(reqReady), 64'd1);
   endtask

   // Main directed sequence.
   initial begin
      testCount = 0;
      failCount = 0;
      rstn      = 1'b0;
      rspReady  = 1'b0;
      datR      = '0;
      ack       = 1'b0;
      err       = 1'b0;
      applyStimulus(1'b0, '0, 1'b0, '0, '0);

      tick();
      tick();
      checkOutput("rst_req_ready", 64'(reqReady), 64'd0);
      checkOutput("rst_cyc", 64'(cyc), 64'd0);
      checkOutput("rst_stb", 64'(stb), 64'd0);
      checkOutput("rst_adr", 64'(adr), 64'd0);
      checkOutput("rst_rsp_valid", 64'(rspValid), 64'd0);
      checkOutput("rst_rsp_dat", 64'(rspDat), 64'd0);
      rstn = 1'b1;
      #1;
      checkOutput("post_rst_req_ready", 64'(reqReady), 64'd1);

      // Write held for three bus cycles, ACK in the third.
      applyStimulus(1'b1, 32'h0000_1000, 1'b1, 4'hF, 32'hDEAD_BEEF);
      tick();
      reqValid = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         checkOutput("wr_cyc", 64'(cyc), 64'd1);
         checkOutput("wr_stb", 64'(stb), 64'd1);
         checkOutput("wr_adr", 64'(adr), 64'h1000);
         checkOutput("wr_we", 64'(we), 64'd1);
         checkOutput("wr_sel", 64'(sel), 64'hF);
         checkOutput("wr_dat_w", 64'(datW), 64'hDEAD_BEEF);
         checkOutput("wr_req_ready", 64'(reqReady), 64'd0);
         checkOutput("wr_no_rsp", 64'(rspValid), 64'd0);
         if (i == 3) ack = 1'b1;
         tick();
      end
      ack = 1'b0;
      checkOutput("wr_cyc_drop", 64'(cyc), 64'd0);
      checkOutput("wr_stb_drop", 64'(stb), 64'd0);
      checkOutput("wr_rsp_valid", 64'(rspValid), 64'd1);
      checkOutput("wr_rsp_err", 64'(rspErr), 64'd0);
      checkOutput("wr_rsp_dat", 64'(rspDat), 64'd0);
      checkOutput("wr_rsp_timeout", 64'(rspTimeout), 64'd0);
      drainResponse("wr");

      // Stray ACK/ERR while idle must not start anything.
      ack = 1'b1;
      err = 1'b1;
      tick();
      ack = 1'b0;
      err = 1'b0;
      checkOutput("stray_cyc", 64'(cyc), 64'd0);
      checkOutput("stray_rsp_valid", 64'(rspValid), 64'd0);
      checkOutput("stray_req_ready", 64'(reqReady), 64'd1);

      // Minimum-latency read, then five cycles of response backpressure.
      applyStimulus(1'b1, 32'h0000_2004, 1'b0, 4'hF, 32'h0);
      tick();
      reqValid = 1'b0;
      checkOutput("rd_cyc", 64'(cyc), 64'd1);
      checkOutput("rd_we", 64'(we), 64'd0);
      checkOutput("rd_adr", 64'(adr), 64'h2004);
      checkOutput("rd_no_rsp_yet", 64'(rspValid), 64'd0);
      ack  = 1'b1;
      datR = 32'h1234_5678;
      tick();
      ack  = 1'b0;
      datR = 32'hFFFF_0000;
      applyStimulus(1'b1, 32'h0000_9999, 1'b1, 4'h1, 32'h5555_5555);
      for (int i = 0; i < 5; i++) begin
         checkOutput("bp_rsp_valid", 64'(rspValid), 64'd1);
         checkOutput("bp_rsp_dat", 64'(rspDat), 64'h1234_5678);
         checkOutput("bp_rsp_err", 64'(rspErr), 64'd0);
         checkOutput("bp_req_ready", 64'(reqReady), 64'd0);
         checkOutput("bp_cyc", 64'(cyc), 64'd0);
         tick();
      end
      reqValid = 1'b0;
      checkOutput("bp_rsp_still_valid", 64'(rspValid), 64'd1);
      drainResponse("rd");
      checkOutput("bp_req_ignored", 64'(cyc), 64'd0);

      // ACK and ERR together are reported as an error with zero data.
      applyStimulus(1'b1, 32'h0000_3000, 1'b0, 4'hF, 32'h0);
      tick();
      reqValid = 1'b0;
      ack  = 1'b1;
      err  = 1'b1;
      datR = 32'hAAAA_5555;
      tick();
      ack = 1'b0;
      err = 1'b0;
      checkOutput("ackerr_rsp_valid", 64'(rspValid), 64'd1);
      checkOutput("ackerr_rsp_err", 64'(rspErr), 64'd1);
      checkOutput("ackerr_rsp_dat", 64'(rspDat), 64'd0);
      checkOutput("ackerr_rsp_timeout", 64'(rspTimeout), 64'd0);
      checkOutput("ackerr_cyc", 64'(cyc), 64'd0);
      drainResponse("ackerr");

`ifdef WB_MASTER_BFM_ENGINE_TIMEOUT_EN
      // No ACK: cycle aborts after four bus cycles.
      applyStimulus(1'b1, 32'h0000_4000, 1'b0, 4'hF, 32'h0);
      tick();
      reqValid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checkOutput("tmo_cyc_held", 64'(cyc), 64'd1);
         checkOutput("tmo_no_rsp", 64'(rspValid), 64'd0);
         tick();
      end
      checkOutput("tmo_cyc_drop", 64'(cyc), 64'd0);
      checkOutput("tmo_rsp_valid", 64'(rspValid), 64'd1);
      checkOutput("tmo_rsp_err", 64'(rspErr), 64'd1);
      checkOutput("tmo_rsp_timeout", 64'(rspTimeout), 64'd1);
      checkOutput("tmo_rsp_dat", 64'(rspDat), 64'd0);
      drainResponse("tmo");

      // ACK on the edge the counter expires wins over the timeout.
      applyStimulus(1'b1, 32'h0000_4100, 1'b0, 4'hF, 32'h0);
      tick();
      reqValid = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      checkOutput("tmo_prio_cyc", 64'(cyc), 64'd1);
      ack  = 1'b1;
      datR = 32'h0000_0055;
      tick();
      ack = 1'b0;
      checkOutput("tmo_prio_rsp_valid", 64'(rspValid), 64'd1);
      checkOutput("tmo_prio_rsp_err", 64'(rspErr), 64'd0);
      checkOutput("tmo_prio_rsp_timeout", 64'(rspTimeout), 64'd0);
      checkOutput("tmo_prio_rsp_dat", 64'(rspDat), 64'h55);
      drainResponse("tmo_prio");
`else
      // Without the timeout the cycle waits indefinitely.
      applyStimulus(1'b1, 32'h0000_4000, 1'b0, 4'hF, 32'h0);
      tick();
      reqValid = 1'b0;
      for (int i = 0; i < 100; i++) begin
         checkOutput("wait_cyc_held", 64'(cyc), 64'd1);
         checkOutput("wait_no_rsp", 64'(rspValid), 64'd0);
         checkOutput("wait_no_timeout", 64'(rspTimeout), 64'd0);
         tick();
      end
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      checkOutput("wait_rst_cyc", 64'(cyc), 64'd0);
`endif

      // Reset in the second bus cycle discards the transaction; SEL=0 passes through.
      applyStimulus(1'b1, 32'h0000_5000, 1'b1, 4'h0, 32'h0BAD_F00D);
      tick();
      reqValid = 1'b0;
      checkOutput("mid_sel_zero", 64'(sel), 64'd0);
      checkOutput("mid_cyc", 64'(cyc), 64'd1);
      tick();
      rstn = 1'b0;
      tick();
      checkOutput("mid_rst_cyc", 64'(cyc), 64'd0);
      checkOutput("mid_rst_stb", 64'(stb), 64'd0);
      checkOutput("mid_rst_rsp", 64'(rspValid), 64'd0);
      checkOutput("mid_rst_req_ready", 64'(reqReady), 64'd0);
      rstn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checkOutput("post_rst_no_rsp", 64'(rspValid), 64'd0);
         checkOutput("post_rst_cyc", 64'(cyc), 64'd0);
         tick();
      end

      // Fresh command after reset completes normally.
      applyStimulus(1'b1, 32'h0000_6000, 1'b0, 4'h3, 32'h0);
      tick();
      reqValid = 1'b0;
      checkOutput("again_adr", 64'(adr), 64'h6000);
      checkOutput("again_sel", 64'(sel), 64'h3);
      ack  = 1'b1;
      datR = 32'h1122_3344;
      tick();
      ack = 1'b0;
      checkOutput("again_rsp_valid", 64'(rspValid), 64'd1);
      checkOutput("again_rsp_err", 64'(rspErr), 64'd0);
      checkOutput("again_rsp_dat", 64'(rspDat), 64'h1122_3344);
      drainResponse("again");

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/wb_master_bfm_engine.md
WB_MASTER_BFM_ENGINE -- requirements
Module: wb_master_bfm_engine

Interface
REQ-001 SHALL have parameter WB_ADDR_WIDTH, default 32, Wishbone address width.
REQ-002 SHALL have parameter WB_DATA_WIDTH, default 32, Wishbone data width, multiple of 8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, bus-wait limit in clocks, range 1..65535.
REQ-004 Port clk, input, 1: clock; all logic on rising edge.
REQ-005 Port rstn, input, 1: reset, synchronous, active-low.
REQ-006 Ports req_valid (in, 1) and req_ready (out, 1): command handshake.
REQ-007 Ports req_adr (in, WB_ADDR_WIDTH), req_we (in, 1), req_sel (in, WB_DATA_WIDTH/8), req_dat (in, WB_DATA_WIDTH): command payload.
REQ-008 Ports rsp_valid (out, 1) and rsp_ready (in, 1): response handshake.
REQ-009 Ports rsp_dat (out, WB_DATA_WIDTH), rsp_err (out, 1), rsp_timeout (out, 1): response payload.
REQ-010 Ports CYC, STB, WE (out, 1), ADR (out, WB_ADDR_WIDTH), SEL (out, WB_DATA_WIDTH/8), DAT_W (out, WB_DATA_WIDTH): Wishbone master outputs, all registered.
REQ-011 Ports DAT_R (in, WB_DATA_WIDTH), ACK (in, 1), ERR (in, 1): Wishbone master inputs.

Function
REQ-012 SHALL implement FSM with states IDLE, BUS, RSP; one transaction outstanding at most.
REQ-013 IDLE: req_ready=1; on edge with req_valid=1, SHALL register ADR/WE/SEL/DAT_W from payload, set CYC=STB=1, go BUS.
REQ-014 req_ready SHALL be 0 in BUS and RSP; req_valid there SHALL be ignored.
REQ-015 BUS: CYC/STB/ADR/WE/SEL/DAT_W SHALL hold stable until termination.
REQ-016 BUS: edge with ACK=1 or ERR=1 SHALL terminate: CYC=STB=0 from next cycle, rsp_valid=1 from next cycle, go RSP.
REQ-017 Simultaneous ACK and ERR SHALL be treated as ERR (rsp_err=1).
REQ-018 rsp_dat SHALL capture DAT_R on ACK-terminated read; SHALL be 0 for writes, errors and timeouts.
REQ-019 RSP: rsp_valid and payload SHALL hold until edge with rsp_ready=1, then go IDLE with rsp_valid=0.
REQ-020 Minimum latency: req accepted edge N, CYC high cycle N+1, ACK at edge N+1 -> rsp_valid high cycle N+2; back-to-back commands incur one IDLE cycle.
REQ-021 ACK/ERR outside BUS SHALL be ignored with no state change.
REQ-022 SEL=0 SHALL be issued on bus unmodified; no address/width checking.

Reset
REQ-023 On edge with rstn=0: state=IDLE; CYC, STB, WE, ADR, SEL, DAT_W, rsp_valid, rsp_dat, rsp_err, rsp_timeout, timeout counter all 0; req_ready=0 during reset, 1 the first cycle after rstn=1.
REQ-024 Reset mid-BUS or mid-RSP SHALL drop CYC/STB at that edge and discard the transaction; no response issued.

Configuration
REQ-025 Macro WB_MASTER_BFM_ENGINE_TIMEOUT_EN defined: counter cleared on BUS entry, incremented each BUS cycle without ACK/ERR; on reaching TIMEOUT_CYCLES SHALL terminate as in REQ-016 with rsp_err=1, rsp_timeout=1, rsp_dat=0.
REQ-026 ACK/ERR on the same edge the counter reaches TIMEOUT_CYCLES SHALL take priority over timeout.
REQ-027 Macro undefined: no counter logic; BUS waits indefinitely; rsp_timeout tied 0.

Verification
REQ-028 Write: req adr=0x1000, we=1, sel=0xF, dat=0xDEADBEEF; ACK after 3 bus cycles -> bus holds values 3 cycles, CYC drops next cycle, rsp_err=0, rsp_dat=0.
REQ-029 Read: adr=0x2004, we=0; ACK with DAT_R=0x12345678 in first BUS cycle -> rsp_valid cycle N+2, rsp_dat=0x12345678.
REQ-030 Backpressure: rsp_ready low 5 cycles after read response -> rsp_valid/rsp_dat stable 5 cycles, req_ready=0, CYC=0 throughout.
REQ-031 ACK=ERR=1 same edge -> rsp_err=1, rsp_dat=0.
REQ-032 TIMEOUT_EN, TIMEOUT_CYCLES=4, no ACK -> CYC drops after 4 BUS cycles, rsp_err=1, rsp_timeout=1; macro undefined -> CYC held 100 cycles, no response.
REQ-033 rstn=0 during BUS cycle 2 -> CYC=0 next cycle, no rsp_valid; new command after reset completes normally.
